// File: rtl/shape_frame_deserializer_pkg.sv
// Shared definitions for the shape stream deserializer: FSM states, header field
// positions, default frame tag and drop counter width.
package shape_stream_pkg;

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_BODY  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int TAG_MSB = 63;
  localparam int TAG_LSB = 48;
  localparam int CNT_MSB = 7;
  localparam int CNT_LSB = 0;

  localparam logic [15:0] TYPE_ID_DEFAULT = 16'h5348;
  localparam int DROP_CNT_W = 16;

  // True when a header carries the expected tag and element count.
  function automatic logic header_matches(input logic [15:0] tag_field,
                                          input logic [7:0]  cnt_field,
                                          input logic [15:0] type_id,
                                          input logic [7:0]  array_len);
    return (tag_field == type_id) && (cnt_field == array_len);
  endfunction

endpackage

// File: rtl/shape_frame_deserializer_if.sv
// Word stream in, shape record out. The master side feeds words and accepts records;
// the slave side is the deserializer.
interface shape_frame_deserializer_if #(
  parameter int WORD_W    = 64,
  parameter int ELEM_W    = 39,
  parameter int ARRAY_LEN = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic [WORD_W-1:0]           in_data;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic [ARRAY_LEN*ELEM_W-1:0] out_array;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_array
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_array
  );
endinterface

// File: rtl/shape_frame_deserializer_sat_counter.sv
// Saturating up-counter: advances by one on each inc pulse and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/shape_frame_deserializer.sv
// Checks frame headers on a 64-bit word stream and packs the body words of a
// well-formed frame into one shape record; malformed frames are discarded and counted.
module shape_frame_deserializer
  import shape_stream_pkg::*;
#(
  parameter int          WORD_W    = 64,
  parameter int          ELEM_W    = 39,
  parameter int          ARRAY_LEN = 4,
  parameter logic [15:0] TYPE_ID   = TYPE_ID_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  shape_frame_deserializer_if.slave io,
  output logic [DROP_CNT_W-1:0]  drop_count
);

  localparam logic [7:0] LEN_FIELD = 8'(ARRAY_LEN);
  localparam logic [7:0] LAST_IDX  = 8'(ARRAY_LEN - 1);

  state_t     state_reg;
  logic [7:0] idx_reg;
  logic       in_ready_reg;
  logic       out_valid_reg;

  logic accept;
  logic hdr_good;
  logic idx_at_end;
  logic body_wr;
  logic drop_inc;

  assign accept     = io.in_valid && in_ready_reg;
  assign hdr_good   = header_matches(io.in_data[TAG_MSB:TAG_LSB],
                                     io.in_data[CNT_MSB:CNT_LSB],
                                     TYPE_ID, LEN_FIELD);
  assign idx_at_end = (idx_reg == LAST_IDX);
  assign body_wr    = accept && (state_reg == ST_BODY);

  // A frame is counted as dropped on the beat that ends it, never on reset.
  always_comb begin
    drop_inc = 1'b0;
    case (state_reg)
      ST_HDR:   drop_inc = accept && io.in_last;
      ST_BODY:  drop_inc = accept && io.in_last && !idx_at_end;
      ST_DRAIN: drop_inc = accept && io.in_last;
      default:  drop_inc = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_HDR;
      idx_reg       <= 8'd0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_HDR: begin
          if (accept) begin
            if (hdr_good && !io.in_last) begin
              state_reg <= ST_BODY;
              idx_reg   <= 8'd0;
            end else if (!io.in_last) begin
              state_reg <= ST_DRAIN;
            end
          end
        end
        ST_BODY: begin
          if (accept) begin
            idx_reg <= idx_reg + 8'd1;
            if (io.in_last) begin
              if (idx_at_end) begin
                state_reg     <= ST_HOLD;
                in_ready_reg  <= 1'b0;
                out_valid_reg <= 1'b1;
              end else begin
                state_reg <= ST_HDR;
                idx_reg   <= 8'd0;
              end
            end else if (idx_at_end) begin
              state_reg <= ST_DRAIN;
              idx_reg   <= 8'd0;
            end
          end
        end
        ST_HOLD: begin
          if (io.out_ready) begin
            state_reg     <= ST_HDR;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (accept && io.in_last) begin
            state_reg <= ST_HDR;
          end
        end
        default: begin
          state_reg     <= ST_HDR;
          idx_reg       <= 8'd0;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // One register per element; only the slot selected by idx takes a body word.
  genvar gi;
  generate
    for (gi = 0; gi < ARRAY_LEN; gi++) begin : g_elem
      logic [ELEM_W-1:0] elem_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          elem_reg <= '0;
        end else if (body_wr && (idx_reg == 8'(gi))) begin
          elem_reg <= io.in_data[ELEM_W-1:0];
        end
      end

      assign io.out_array[gi*ELEM_W +: ELEM_W] = elem_reg;
    end
  endgenerate

  assign io.in_ready  = in_ready_reg;
  assign io.out_valid = out_valid_reg;

  sat_counter #(
    .W (DROP_CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_inc),
    .count (drop_count)
  );

endmodule

// File: tb/tb_shape_frame_deserializer.sv
// Self-checking bench: directed table of frames, hand sequences for backpressure,
// saturation and reset, and random frames checked against a frame-level model.
module tb_shape_frame_deserializer;
  import shape_stream_pkg::*;

  localparam int WORD_W    = 64;
  localparam int ELEM_W    = 39;
  localparam int ARRAY_LEN = 4;
  localparam int OUT_W     = ARRAY_LEN * ELEM_W;
  localparam logic [63:0] GOOD_HDR = 64'h5348_0000_0000_0004;
  localparam logic [63:0] BAD_HDR  = 64'h1234_0000_0000_0004;

  typedef logic [63:0] wq_t[$];
  typedef struct {
    logic [63:0] hdr;
    int          nbody;
    bit          exp_ok;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DROP_CNT_W-1:0] drop_count;

  always #5 clk = ~clk;

  shape_frame_deserializer_if #(.WORD_W(WORD_W), .ELEM_W(ELEM_W), .ARRAY_LEN(ARRAY_LEN)) bus ();

  shape_frame_deserializer #(
    .WORD_W(WORD_W), .ELEM_W(ELEM_W), .ARRAY_LEN(ARRAY_LEN), .TYPE_ID(16'h5348)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .io         (bus.slave),
    .drop_count (drop_count)
  );

  int checks = 0;
  int failures = 0;
  int delivered = 0;
  int model_drops = 0;
  bit rand_rdy = 1'b0;
  logic [OUT_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit frame_ok(input logic [63:0] hdr, input int nbody);
    return (hdr[63:48] == 16'h5348) && (hdr[7:0] == 8'(ARRAY_LEN)) && (nbody == ARRAY_LEN);
  endfunction

  function automatic wq_t rand_body(input int n);
    wq_t q;
    for (int i = 0; i < n; i++) q.push_back({$urandom, $urandom});
    return q;
  endfunction

  function automatic logic [15:0] model_count();
    return (model_drops > 65535) ? 16'hFFFF : 16'(model_drops);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(input logic [63:0] d, input logic l);
    bit hs;
    int n;
    hs = 1'b0;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!hs && n < 2000) begin
      @(negedge clk);
      hs = bus.in_ready;
      tick();
      n++;
    end
    if (!hs) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=stalled required=accepted");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] hdr, input wq_t body, input bit gaps);
    logic [OUT_W-1:0] elems;
    int nb;
    nb = body.size();
    elems = '0;
    send_word(hdr, nb == 0);
    for (int i = 0; i < nb; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      if (i < ARRAY_LEN) elems[i*ELEM_W +: ELEM_W] = body[i][ELEM_W-1:0];
      send_word(body[i], i == nb - 1);
    end
    if (frame_ok(hdr, nb)) exp_q.push_back(elems);
    else model_drops++;
  endtask

  // Output monitor: record contents, stall stability and input-hold rule.
  logic [OUT_W-1:0] prev_arr;
  logic [63:0]      prev_d;
  logic             prev_l;
  bit               prev_stall = 1'b0;
  bit               prev_in_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall    = 1'b0;
      prev_in_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", bus.out_valid, 1'b1);
        chk("hold_stable", bus.out_array, prev_arr);
      end
      if (prev_in_stall) chk("in_stable", {bus.in_valid, bus.in_last, bus.in_data}, {1'b1, prev_l, prev_d});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_record actual=%0h required=none", bus.out_array);
        end else begin
          chk("record", bus.out_array, exp_q.pop_front());
        end
        delivered++;
        $display("record %0d array=%0h", delivered, bus.out_array);
      end
      prev_stall    = bus.out_valid && !bus.out_ready;
      prev_arr      = bus.out_array;
      prev_in_stall = bus.in_valid && !bus.in_ready;
      prev_d        = bus.in_data;
      prev_l        = bus.in_last;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[9];
    wq_t  body;
    logic [OUT_W-1:0] saved;
    int   tbl_drops;
    int   d_before;
    logic [63:0] hdr;
    int   kind;
    int   nb;

    vecs[0] = '{hdr: BAD_HDR,                 nbody: 4, exp_ok: 1'b0};
    vecs[1] = '{hdr: 64'h5348_0000_0000_0003, nbody: 4, exp_ok: 1'b0};
    vecs[2] = '{hdr: GOOD_HDR,                nbody: 2, exp_ok: 1'b0};
    vecs[3] = '{hdr: GOOD_HDR,                nbody: 6, exp_ok: 1'b0};
    vecs[4] = '{hdr: GOOD_HDR,                nbody: 0, exp_ok: 1'b0};
    vecs[5] = '{hdr: 64'h5348_FFFF_FFFF_FF04, nbody: 4, exp_ok: 1'b1};
    vecs[6] = '{hdr: 64'h5348_0000_0000_0104, nbody: 4, exp_ok: 1'b1};
    vecs[7] = '{hdr: 64'h5349_0000_0000_0004, nbody: 4, exp_ok: 1'b0};
    vecs[8] = '{hdr: GOOD_HDR,                nbody: 4, exp_ok: 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_in_ready", bus.in_ready, 1'b1);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_drop_count", drop_count, 16'd0);
    chk("reset_out_array", bus.out_array, '0);

    // Good frame with upper body bits set; output lasts one cycle.
    body = {64'hFFFF_FF80_DEAD_BEEF, 64'd1, 64'd2, 64'd3};
    send_frame(GOOD_HDR, body, 1'b0);
    chk("good_valid_rise", bus.out_valid, 1'b1);
    chk("good_elem0", bus.out_array[0 +: ELEM_W], 39'h00DEADBEEF);
    chk("good_elem3", bus.out_array[3*ELEM_W +: ELEM_W], 39'd3);
    tick();
    chk("good_valid_fall", bus.out_valid, 1'b0);
    chk("good_drop_count", drop_count, 16'd0);
    $display("frame good delivered=%0d", delivered);

    // Backpressure with the next header waiting.
    bus.out_ready = 1'b0;
    send_frame(GOOD_HDR, rand_body(4), 1'b0);
    saved = bus.out_array;
    bus.in_valid = 1'b1;
    bus.in_data  = GOOD_HDR;
    bus.in_last  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_out_valid", bus.out_valid, 1'b1);
      chk("bp_array", bus.out_array, saved);
      if (k == 7) bus.out_ready = 1'b1;
      tick();
    end
    chk("bp_release_valid", bus.out_valid, 1'b0);
    chk("bp_release_ready", bus.in_ready, 1'b1);
    d_before = delivered;
    send_frame(GOOD_HDR, rand_body(4), 1'b0);
    tick();
    tick();
    chk("bp_second_frame", delivered - d_before, 1);
    $display("frame backpressure delivered=%0d", delivered);

    // Table of directed frames.
    tbl_drops = 0;
    foreach (vecs[i]) begin
      d_before = delivered;
      send_frame(vecs[i].hdr, rand_body(vecs[i].nbody), 1'b0);
      tick();
      tick();
      if (!vecs[i].exp_ok) tbl_drops++;
      chk($sformatf("vec%0d_drop", i), drop_count, 16'(tbl_drops));
      chk($sformatf("vec%0d_deliver", i), delivered - d_before, vecs[i].exp_ok ? 1 : 0);
      $display("vec %0d hdr=%h nbody=%0d drops=%0d", i, vecs[i].hdr, vecs[i].nbody, drop_count);
    end

    // Random frames against the frame-level model.
    rand_rdy = 1'b1;
    for (int f = 0; f < 300; f++) begin
      kind = $urandom_range(0, 5);
      hdr  = {16'h5348, $urandom, 8'($urandom), 8'(ARRAY_LEN)};
      nb   = ARRAY_LEN;
      case (kind)
        2: begin
          hdr[63:48] = 16'($urandom);
          if (hdr[63:48] == 16'h5348) hdr[63:48] = 16'h5349;
          nb = $urandom_range(0, 6);
        end
        3: begin
          hdr[7:0] = 8'($urandom);
          if (hdr[7:0] == 8'(ARRAY_LEN)) hdr[7:0] = 8'(ARRAY_LEN + 1);
          nb = $urandom_range(0, 6);
        end
        4: nb = $urandom_range(0, ARRAY_LEN - 1);
        5: nb = $urandom_range(ARRAY_LEN + 1, ARRAY_LEN + 3);
        default: nb = ARRAY_LEN;
      endcase
      repeat ($urandom_range(0, 2)) tick();
      send_frame(hdr, rand_body(nb), 1'b1);
    end
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("rand_drop_count", drop_count, model_count());
    $display("random done delivered=%0d drops=%0d", delivered, drop_count);

    // Saturation of the drop counter.
    bus.in_valid = 1'b1;
    bus.in_data  = BAD_HDR;
    bus.in_last  = 1'b1;
    repeat (65540) tick();
    bus.in_valid = 1'b0;
    tick();
    chk("sat_drop_count", drop_count, 16'hFFFF);
    $display("saturation drops=%0h", drop_count);

    // Reset while holding a record.
    bus.out_ready = 1'b0;
    send_frame(GOOD_HDR, rand_body(4), 1'b0);
    chk("rst_hold_valid", bus.out_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    model_drops = 0;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_drop_count", drop_count, 16'd0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_array", bus.out_array, '0);
    bus.out_ready = 1'b1;
    d_before = delivered;
    send_frame(GOOD_HDR, rand_body(4), 1'b0);
    tick();
    tick();
    chk("post_rst_deliver", delivered - d_before, 1);
    chk("post_rst_drop_count", drop_count, 16'd0);
    $display("reset recovery delivered=%0d", delivered);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
